dram_resp_sim: RTL and testbench

Simulation-side DRAM responder that services the core/MMU DRAM request port: w_dram_addr/wdata/ctrl with w_dram_le (load) and w_dram_we_t (store) strobes, answered through w_dram_busy and w_dram_odata. It holds a word-organised memory array and preloads it from the w_pl_init_* stream before releasing the core. It sits in the simulation top beside m_cpummusim, on the other end of the DRAM interface. It models access latency with a busy handshake and performs byte/halfword/word lane handling.

---
 rtl/dram_resp_sim_if.sv | 31 +++
 rtl/dram_resp_sim.sv | 171 +++++++++++++++++
 tb/tb_dram_resp_sim.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dram_resp_sim_if.sv
// DRAM request/response bus between the core/MMU and the simulated DRAM.
//   master : core side, drives the request (address, store data, size code,
//            load/store strobes) and observes busy and load data.
//   slave  : responder side (dram_resp_sim).
// Signals:
//   w_dram_addr  [31:0] byte address
//   w_dram_wdata [31:0] store data, right-aligned
//   w_dram_ctrl  [2:0]  funct3 size code
//   w_dram_le           load request strobe
//   w_dram_we_t         store request strobe
//   w_dram_busy         responder busy; requests ignored while high
//   w_dram_odata [31:0] load result, extended to 32 bits
interface dram_resp_sim_if;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_le;
  logic        w_dram_we_t;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;

  modport master (
    output w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t,
    input  w_dram_busy, w_dram_odata
  );

  modport slave (
    input  w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t,
    output w_dram_busy, w_dram_odata
  );
endinterface

// File: rtl/dram_resp_sim.sv
// Simulation-side DRAM responder. Holds a word-organised array of 2^ADDR_W
// words, fills it from the preload stream, then services single load/store
// requests with a fixed LATENCY-cycle busy window and byte/halfword/word lane
// handling.
// Ports:
//   CLK             clock, all state on rising edge
//   RST_X           asynchronous active-low reset
//   w_pl_init_we    preload strobe, one word per cycle
//   w_pl_init_data  preload word
//   w_init_done     preload complete (sticky until reset)
//   dram            request/response bus (slave modport)
module dram_resp_sim #(
  parameter int ADDR_W     = 12,
  parameter int LATENCY    = 4,
  parameter int INIT_WORDS = 16
) (
  input  logic            CLK,
  input  logic            RST_X,
  input  logic            w_pl_init_we,
  input  logic [31:0]     w_pl_init_data,
  output logic            w_init_done,
  dram_resp_sim_if.slave  dram
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;

  localparam state_t          RST_STATE = (INIT_WORDS == 0) ? S_IDLE : S_INIT;
  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W + 1)'(INIT_WORDS - 1);
  localparam logic [7:0]      CNT_LOAD  = 8'(LATENCY - 1);

  logic [31:0]       mem [0:(2**ADDR_W)-1];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   init_cnt;
  logic              pl_fire;
  logic              accept;
  logic              finish;

  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        ctrl_q;
  logic              op_st_q;
  logic [31:0]       rd_word;
  logic [31:0]       odata_q;

  // Address bits above the array are aliased away.
  logic addr_hi_unused;
  assign addr_hi_unused = ^dram.w_dram_addr[31:ADDR_W+2];

  // Merge right-aligned store data into the addressed lane; size 11 leaves
  // the word untouched.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old_w;
    case (sz)
      2'b00:   w[{lane, 3'b000} +: 8]        = wd[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16]   = wd[15:0];
      2'b10:   w                             = wd;
      default: w                             = old_w;
    endcase
    return w;
  endfunction

  // Select the addressed lane and extend it to 32 bits by funct3.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [2:0]  c,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (c)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign pl_fire = w_pl_init_we & ~w_init_done;
  assign rd_word = mem[addr_q[ADDR_W+1:2]];

  // Preload counter and sticky done flag
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      init_cnt    <= '0;
      w_init_done <= (INIT_WORDS == 0);
    end else if (pl_fire) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == INIT_LAST) w_init_done <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; INIT leaves on the same edge that raises w_init_done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (pl_fire && (init_cnt == INIT_LAST)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (dram.w_dram_le | dram.w_dram_we_t) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  assign dram.w_dram_busy = (state_q != S_IDLE);

  // Request capture at acceptance; store wins when both strobes are high
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= dram.w_dram_addr[ADDR_W+1:0];
      wdata_q <= dram.w_dram_wdata;
      ctrl_q  <= dram.w_dram_ctrl;
      op_st_q <= dram.w_dram_we_t;
    end
  end

  // Memory array: preload writes and store completion; never reset
  always_ff @(posedge CLK) begin
    if (pl_fire) mem[init_cnt[ADDR_W-1:0]] <= w_pl_init_data;
    if (finish && op_st_q && (ctrl_q[1:0] != 2'b11))
      mem[addr_q[ADDR_W+1:2]] <= store_merge(rd_word, wdata_q, ctrl_q[1:0], addr_q[1:0]);
  end

  // Load result holds until the next load completes
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      odata_q <= '0;
    end else if (finish && !op_st_q) begin
      odata_q <= load_ext(rd_word, ctrl_q, addr_q[1:0]);
    end
  end

  assign dram.w_dram_odata = odata_q;

endmodule

// File: tb/tb_dram_resp_sim.sv
// Bench for dram_resp_sim: two responders (LATENCY=4 and LATENCY=1, both
// INIT_WORDS=4) share clock, reset, preload stream and request bus. Expected
// load results are queued at issue and compared when the access completes.
module tb_dram_resp_sim;
  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        pl_we = 1'b0;
  logic [31:0] pl_data = '0;
  logic        done0, done1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = '0;

  dram_resp_sim_if bus0 ();
  dram_resp_sim_if bus1 ();

  assign bus1.w_dram_addr  = bus0.w_dram_addr;
  assign bus1.w_dram_wdata = bus0.w_dram_wdata;
  assign bus1.w_dram_ctrl  = bus0.w_dram_ctrl;
  assign bus1.w_dram_le    = bus0.w_dram_le;
  assign bus1.w_dram_we_t  = bus0.w_dram_we_t;

  dram_resp_sim #(.ADDR_W(12), .LATENCY(4), .INIT_WORDS(4)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_pl_init_we(pl_we), .w_pl_init_data(pl_data),
    .w_init_done(done0), .dram(bus0)
  );

  dram_resp_sim #(.ADDR_W(12), .LATENCY(1), .INIT_WORDS(4)) dut1 (
    .CLK(CLK), .RST_X(RST_X), .w_pl_init_we(pl_we), .w_pl_init_data(pl_data),
    .w_init_done(done1), .dram(bus1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      pl_we   = 1'b1;
      pl_data = w[i];
      if (i == 3) begin
        chk("done_before_last", 32'(done0), 32'h0);
        chk("busy_before_last", 32'(bus0.w_dram_busy), 32'h1);
      end
    end
    @(negedge CLK);
    pl_we = 1'b0;
    chk("done_after_last", 32'(done0), 32'h1);
    chk("done1_after_last", 32'(done1), 32'h1);
    chk("busy_after_init", 32'(bus0.w_dram_busy), 32'h0);
    chk("busy1_after_init", 32'(bus1.w_dram_busy), 32'h0);
  endtask

  // One request; strobe held for `hold` extra edges into the busy window.
  task automatic access(input string tag, input logic le, input logic we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] c, input int hold, input logic [31:0] exp);
    int n0 = 0;
    int n1 = 0;
    logic is_load;
    logic [31:0] e;
    is_load = le & ~we;
    if (is_load) exp_q.push_back(exp);
    @(negedge CLK);
    bus0.w_dram_addr  = a;
    bus0.w_dram_wdata = wd;
    bus0.w_dram_ctrl  = c;
    bus0.w_dram_le    = le;
    bus0.w_dram_we_t  = we;
    @(posedge CLK);
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (k == hold) begin
        bus0.w_dram_le   = 1'b0;
        bus0.w_dram_we_t = 1'b0;
      end
      if (!bus0.w_dram_busy) break;
      n0++;
      if (bus1.w_dram_busy) n1++;
    end
    chk({tag, "_busy_cycles"}, 32'(n0), 32'd4);
    if (hold == 0) chk({tag, "_busy1_cycles"}, 32'(n1), 32'd1);
    if (is_load) begin
      e = exp_q.pop_front();
      chk({tag, "_odata"}, bus0.w_dram_odata, e);
      chk({tag, "_odata1"}, bus1.w_dram_odata, e);
      last_load = e;
    end else begin
      chk({tag, "_odata_held"}, bus0.w_dram_odata, last_load);
      chk({tag, "_odata1_held"}, bus1.w_dram_odata, last_load);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.w_dram_addr  = '0;
    bus0.w_dram_wdata = '0;
    bus0.w_dram_ctrl  = '0;
    bus0.w_dram_le    = 1'b0;
    bus0.w_dram_we_t  = 1'b0;
    #1;
    chk("rst_busy", 32'(bus0.w_dram_busy), 32'h1);
    chk("rst_busy1", 32'(bus1.w_dram_busy), 32'h1);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_odata", bus0.w_dram_odata, 32'h0);
    chk("rst_odata1", bus1.w_dram_odata, 32'h0);
    repeat (3) @(negedge CLK);
    RST_X = 1'b1;

    preload(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    access("lw_8",   1'b1, 1'b0, 32'h8,    32'h0,        3'b010, 0, 32'h33333333);
    access("sb_5",   1'b0, 1'b1, 32'h5,    32'h00000080, 3'b000, 0, 32'h0);
    access("lw_4",   1'b1, 1'b0, 32'h4,    32'h0,        3'b010, 0, 32'h22228022);
    access("lb_5",   1'b1, 1'b0, 32'h5,    32'h0,        3'b000, 0, 32'hFFFFFF80);
    access("lbu_5",  1'b1, 1'b0, 32'h5,    32'h0,        3'b100, 0, 32'h00000080);
    access("sh_e",   1'b0, 1'b1, 32'hE,    32'h0000BEEF, 3'b001, 0, 32'h0);
    access("lh_e",   1'b1, 1'b0, 32'hE,    32'h0,        3'b001, 0, 32'hFFFFBEEF);
    access("lhu_e",  1'b1, 1'b0, 32'hE,    32'h0,        3'b101, 0, 32'h0000BEEF);
    access("lw_c",   1'b1, 1'b0, 32'hC,    32'h0,        3'b010, 0, 32'hBEEF4444);
    access("sw_alias", 1'b0, 1'b1, 32'h4000, 32'hCAFEF00D, 3'b010, 3, 32'h0);
    access("lw_0",   1'b1, 1'b0, 32'h0,    32'h0,        3'b010, 0, 32'hCAFEF00D);
    access("st_sz3", 1'b0, 1'b1, 32'h4,    32'hFFFFFFFF, 3'b011, 0, 32'h0);
    access("ld_f6",  1'b1, 1'b0, 32'h5,    32'h0,        3'b110, 0, 32'h22228022);
    access("both",   1'b1, 1'b1, 32'h8,    32'h12345678, 3'b010, 0, 32'h0);
    access("lw_8b",  1'b1, 1'b0, 32'h8,    32'h0,        3'b010, 0, 32'h12345678);

    // Reset during the second busy cycle of a word store to address 0
    @(negedge CLK);
    bus0.w_dram_addr  = 32'h0;
    bus0.w_dram_wdata = 32'h0;
    bus0.w_dram_ctrl  = 3'b010;
    bus0.w_dram_we_t  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus0.w_dram_we_t = 1'b0;
    chk("midrst_busy_c1", 32'(bus0.w_dram_busy), 32'h1);
    @(negedge CLK);
    RST_X = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus0.w_dram_busy), 32'h1);
    chk("midrst_busy1", 32'(bus1.w_dram_busy), 32'h1);
    chk("midrst_odata", bus0.w_dram_odata, 32'h0);
    chk("midrst_odata1", bus1.w_dram_odata, 32'h0);
    chk("midrst_done", 32'(done0), 32'h0);
    last_load = '0;
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;

    preload(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    access("re_lw_0", 1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 0, 32'h55555555);
    access("re_lw_c", 1'b1, 1'b0, 32'hC, 32'h0, 3'b010, 0, 32'h88888888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
